// File: rtl/multi_clk_divider.sv
// Multi-channel 50%-duty clock divider with per-channel tick and glitch-free runtime reprogramming.
// Outputs registered; cfg_ready drops for a channel while its shadow config waits for a period boundary.
module multi_clk_divider #(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 50,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk100,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] div_tick,
  output logic [NUM_CH-1:0] ch_active
);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] half_q, half_d;
  logic [NUM_CH-1:0][CNT_W-1:0] pend_half_q, pend_half_d;
  logic [NUM_CH-1:0]            active_q, active_d;
  logic [NUM_CH-1:0]            div_clk_q, div_clk_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            pend_en_q, pend_en_d;
  logic [NUM_CH-1:0]            cfg_sel;
  logic                         cfg_fire;

  // Out-of-range channel indices decode to no channel, so they are accepted and dropped.
  always_comb begin
    cfg_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_sel[i] = 1'b1;
      end
    end
  end

  assign cfg_ready = ~|(cfg_sel & pend_q);
  assign cfg_fire  = cfg_valid & cfg_ready;

  always_comb begin
    cnt_d       = cnt_q;
    half_d      = half_q;
    active_d    = active_q;
    div_clk_d   = div_clk_q;
    tick_d      = '0;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    pend_en_d   = pend_en_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_q[i]) begin
        if (cnt_q[i] == half_q[i]) begin
          cnt_d[i]     = '0;
          div_clk_d[i] = ~div_clk_q[i];
          if (!div_clk_q[i]) begin
            tick_d[i] = 1'b1;
          end else if (pend_q[i]) begin
            // Falling edge closes a full period: the only safe point to swap config.
            half_d[i]   = pend_half_q[i];
            active_d[i] = pend_en_q[i];
            pend_d[i]   = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else begin
        cnt_d[i]     = '0;
        div_clk_d[i] = 1'b0;
        if (pend_q[i]) begin
          half_d[i]   = pend_half_q[i];
          active_d[i] = pend_en_q[i];
          pend_d[i]   = 1'b0;
        end
      end
      // A transfer needs pend clear, so it never collides with an apply above.
      if (cfg_fire && cfg_sel[i]) begin
        pend_d[i]      = 1'b1;
        pend_half_d[i] = cfg_half;
        pend_en_d[i]   = cfg_en;
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]       <= '0;
        half_q[i]      <= CNT_W'(DEFAULT_HALF);
        pend_half_q[i] <= CNT_W'(DEFAULT_HALF);
      end
      active_q  <= '1;
      div_clk_q <= '0;
      tick_q    <= '0;
      pend_q    <= '0;
      pend_en_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      pend_half_q <= pend_half_d;
      active_q    <= active_d;
      div_clk_q   <= div_clk_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_en_q   <= pend_en_d;
    end
  end

  assign div_clk   = div_clk_q;
  assign div_tick  = tick_q;
  assign ch_active = active_q;

endmodule
